nn_layer_mac: RTL

Parametrised fully-connected layer for the fpgaDNN datapath. It holds an on-chip weight and bias store for NUM_NEURONS neurons. It accepts one input activation per handshake and updates all neuron accumulators in parallel with that input. After NUM_WEIGHTS inputs it applies bias, optional ReLU and saturation, then presents all neuron outputs together on one bus. It is the generalised successor to the fixed 16-bit, per-neuron-wired layers: width, fixed-point format, depth and activation are configurable, and it has ready/valid backpressure on both sides.

---
 rtl/nn_layer_mac.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/nn_layer_mac.sv
// Fully-connected layer: per-neuron weight/bias store and accumulator.
// Every accepted input updates all neurons in parallel; after
// NUM_WEIGHTS inputs the layer adds bias, applies the activation,
// saturates, and presents all neuron results together.

module nn_layer_mac_neuron #(
  parameter int NUM_WEIGHTS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ACT_MODE    = 1,
  parameter int IW          = 5,
  parameter int AW          = 38
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic        [IW-1:0]         w_idx,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic                         acc_en,
  input  logic        [IW-1:0]         cnt,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         fin_en,
  output logic        [DATA_WIDTH-1:0] y
);
  localparam int DW = DATA_WIDTH;
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0]   w_q [NUM_WEIGHTS];
  logic signed [DW-1:0]   b_q;
  logic signed [DW-1:0]   w_sel;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc_q, r;
  logic        [DW-1:0]   y_q, y_d;

  // Weight/bias store; left untouched by reset so weights survive it.
  // Indices past the bias slot fall through and are dropped.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_WEIGHTS; i++)
        if (w_idx == IW'(i)) w_q[i] <= w_in;
      if (w_idx == IW'(NUM_WEIGHTS)) b_q <= w_in;
    end
  end

  // Select the weight for the current input position.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_WEIGHTS; i++)
      if (cnt == IW'(i)) w_sel = w_q[i];
  end

  assign prod = $signed((2*DW)'(x_in)) * $signed((2*DW)'(w_sel));

  // Accumulator: cleared on reset and once the frame result is taken.
  always_ff @(posedge clk) begin
    if (rst || fin_en) acc_q <= '0;
    else if (acc_en)   acc_q <= acc_q + AW'(prod);
  end

  // Rescale, add bias, activation, then clamp to the output range.
  always_comb begin
    r = (acc_q >>> FRAC_BITS) + AW'(b_q);
    if (ACT_MODE == 1 && r[AW-1]) r = '0;
    if (r > MAXV)      y_d = MAXV[DW-1:0];
    else if (r < MINV) y_d = MINV[DW-1:0];
    else               y_d = r[DW-1:0];
  end

  // Output register; holds its value until the next frame completes.
  always_ff @(posedge clk) begin
    if (rst)         y_q <= '0;
    else if (fin_en) y_q <= y_d;
  end

  assign y = y_q;
endmodule

module nn_layer_mac #(
  parameter int NUM_NEURONS = 10,
  parameter int NUM_WEIGHTS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int ACT_MODE    = 1,
  parameter int NB = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter int IW = $clog2(NUM_WEIGHTS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             w_in,
  input  logic [NB-1:0]                     w_neuron,
  input  logic [IW-1:0]                     w_idx,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [DATA_WIDTH-1:0]             x_in,
  input  logic                              x_valid,
  output logic                              x_ready,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] x_out,
  output logic                              o_valid,
  input  logic                              o_ready
);
  localparam int AW = 2*DATA_WIDTH + $clog2(NUM_WEIGHTS) + 1;

  typedef enum logic [1:0] {ACCUM, FINISH, OUT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          ov_q, ov_d;
  logic          x_acc, w_acc, fin_en;

  assign x_ready = (state_q == ACCUM);
  assign w_ready = x_ready && (cnt_q == '0);
  assign o_valid = ov_q;
  assign x_acc   = x_valid && x_ready;
  assign w_acc   = w_valid && w_ready;
  assign fin_en  = (state_q == FINISH);

  // State, input counter and output-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
    end
  end

  // Frame sequencing: accumulate, one finish cycle, hold until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    case (state_q)
      ACCUM: if (x_acc) begin
        if (cnt_q == IW'(NUM_WEIGHTS - 1)) begin
          cnt_d   = '0;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      FINISH: begin
        ov_d    = 1'b1;
        state_d = OUT;
      end
      OUT: if (o_ready) begin
        ov_d    = 1'b0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_n
    nn_layer_mac_neuron #(
      .NUM_WEIGHTS(NUM_WEIGHTS), .DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS),
      .ACT_MODE(ACT_MODE), .IW(IW), .AW(AW)
    ) u_n (
      .clk   (clk),
      .rst   (rst),
      .wr_en (w_acc && (w_neuron == NB'(k))),
      .w_idx (w_idx),
      .w_in  (w_in),
      .acc_en(x_acc),
      .cnt   (cnt_q),
      .x_in  (x_in),
      .fin_en(fin_en),
      .y     (x_out[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule
